// File: rtl/dcache_pkg.sv
// Shared constants and types for the D-cache tag lookup/maintenance engine.
// Tag RAM entry layout is {valid, tag}; the stats macro is DCACHE_TAG_STATS_EN.
package dcache_pkg;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 9;
    localparam int OFS_W  = 3;
    localparam int TAG_W  = ADDR_W - IDX_W - OFS_W;
    localparam int DEPTH  = 1 << IDX_W;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic {
        WC_FILL  = 1'b0,
        WC_INVAL = 1'b1
    } wc_op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // RAM word written by a write command: fill stores {1,tag}, invalidate clears the word.
    function automatic tag_entry_t wc_entry(input wc_op_e op, input logic [TAG_W-1:0] tag);
        tag_entry_t e;
        e.valid = (op == WC_FILL);
        e.tag   = (op == WC_FILL) ? tag : '0;
        return e;
    endfunction

endpackage

// File: rtl/dcache_tag_fwd.sv
// S1 tag compare with write forwarding around the RAM read-during-write hazard.
// A write in the current cycle overrides the registered write from the previous cycle.
module dcache_tag_fwd
    import dcache_pkg::*;
(
    input  tag_entry_t       i_rd_data,
    input  logic             i_wq_valid,
    input  logic [IDX_W-1:0] i_wq_idx,
    input  tag_entry_t       i_wq_data,
    input  logic             i_wc_valid,
    input  logic [IDX_W-1:0] i_wc_idx,
    input  tag_entry_t       i_wc_data,
    input  logic [IDX_W-1:0] i_s1_idx,
    input  logic [TAG_W-1:0] i_s1_tag,
    output logic             o_hit,
    output tag_entry_t       o_entry
);

    tag_entry_t w_entry;

    always_comb begin
        w_entry = i_rd_data;
        if (i_wq_valid && (i_wq_idx == i_s1_idx)) begin
            w_entry = i_wq_data;
        end
        if (i_wc_valid && (i_wc_idx == i_s1_idx)) begin
            w_entry = i_wc_data;
        end
    end

    assign o_entry = w_entry;
    assign o_hit   = w_entry.valid && (w_entry.tag == i_s1_tag);

endmodule

// File: rtl/dcache_tag_ctrl.sv
// D-cache tag RAM controller: post-reset clear sweep, pipelined lookups, fill/invalidate writes.
// Optional hit/miss counters are built when DCACHE_TAG_STATS_EN is defined.
module dcache_tag_ctrl
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              rsp_valid,
    output logic              rsp_hit,
    output logic [TAG_W-1:0]  rsp_victim_tag,
    output logic              rsp_victim_valid,
    input  logic              wc_valid,
    output logic              wc_ready,
    input  logic              wc_op,
    input  logic [ADDR_W-1:0] wc_addr,
    output logic [IDX_W-1:0]  tag_rd_addr,
    input  logic [TAG_W:0]    tag_rd_data,
    output logic [IDX_W-1:0]  tag_wr_addr,
    output logic [TAG_W:0]    tag_wr_data,
    output logic              tag_wr_en,
    output logic              init_done
`ifdef DCACHE_TAG_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    state_e           r_state;
    state_e           w_state_next;
    logic [IDX_W-1:0] r_count;

    logic             w_run;
    logic             w_lk_acc;
    logic             w_wc_acc;
    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_wc_idx;
    logic [TAG_W-1:0] w_wc_tag;
    tag_entry_t       w_wr_entry;
    logic             w_unused_ofs;

    logic [IDX_W-1:0] r_rd_addr;
    logic             r_s1_valid;
    logic [TAG_W-1:0] r_s1_tag;
    logic [IDX_W-1:0] r_s1_idx;

    logic             r_wq_valid;
    logic [IDX_W-1:0] r_wq_idx;
    tag_entry_t       r_wq_data;

    logic             w_fwd_hit;
    tag_entry_t       w_fwd_entry;

    logic             r_rsp_valid;
    logic             r_rsp_hit;
    tag_entry_t       r_rsp_entry;

    assign w_lk_tag     = lk_addr[ADDR_W-1 -: TAG_W];
    assign w_lk_idx     = lk_addr[OFS_W +: IDX_W];
    assign w_wc_tag     = wc_addr[ADDR_W-1 -: TAG_W];
    assign w_wc_idx     = wc_addr[OFS_W +: IDX_W];
    assign w_unused_ofs = ^{lk_addr[OFS_W-1:0], wc_addr[OFS_W-1:0]};

    assign w_run    = (r_state == ST_RUN);
    assign w_lk_acc = lk_valid && w_run;
    assign w_wc_acc = wc_valid && w_run;

    assign lk_ready  = w_run;
    assign wc_ready  = w_run;
    assign init_done = w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if ((r_state == ST_INIT) && (r_count == IDX_W'(DEPTH - 1))) begin
            w_state_next = ST_RUN;
        end
    end

    // Sweep writes are held off while rst is high so the sweep starts on the first free cycle.
    always_comb begin
        tag_wr_en   = 1'b0;
        tag_wr_addr = w_wc_idx;
        w_wr_entry  = '0;
        if (r_state == ST_INIT) begin
            tag_wr_en   = !rst;
            tag_wr_addr = r_count;
        end else if (w_wc_acc) begin
            tag_wr_en   = 1'b1;
            w_wr_entry  = wc_entry(wc_op_e'(wc_op), w_wc_tag);
        end
    end

    assign tag_wr_data = w_wr_entry;
    assign tag_rd_addr = w_lk_acc ? w_lk_idx : r_rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_tag   <= '0;
            r_s1_idx   <= '0;
            r_wq_valid <= 1'b0;
            r_wq_idx   <= '0;
            r_wq_data  <= '0;
        end else begin
            r_s1_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_rd_addr <= w_lk_idx;
                r_s1_tag  <= w_lk_tag;
                r_s1_idx  <= w_lk_idx;
            end
            r_wq_valid <= tag_wr_en;
            r_wq_idx   <= tag_wr_addr;
            r_wq_data  <= w_wr_entry;
        end
    end

    dcache_tag_fwd u_fwd (
        .i_rd_data  (tag_rd_data),
        .i_wq_valid (r_wq_valid),
        .i_wq_idx   (r_wq_idx),
        .i_wq_data  (r_wq_data),
        .i_wc_valid (tag_wr_en),
        .i_wc_idx   (tag_wr_addr),
        .i_wc_data  (w_wr_entry),
        .i_s1_idx   (r_s1_idx),
        .i_s1_tag   (r_s1_tag),
        .o_hit      (w_fwd_hit),
        .o_entry    (w_fwd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_entry <= '0;
        end else begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_hit   <= w_fwd_hit;
                r_rsp_entry <= w_fwd_entry;
            end
        end
    end

    assign rsp_valid        = r_rsp_valid;
    assign rsp_hit          = r_rsp_hit;
    assign rsp_victim_tag   = r_rsp_entry.tag;
    assign rsp_victim_valid = r_rsp_entry.valid;

`ifdef DCACHE_TAG_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (w_run && r_rsp_valid) begin
            if (r_rsp_hit) begin
                if (r_stat_hits != '1) begin
                    r_stat_hits <= r_stat_hits + 32'd1;
                end
            end else if (r_stat_misses != '1) begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`else
    // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: behavioural tag RAM plus a response scoreboard.
module tb_dcache_tag_ctrl;
    import dcache_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              lk_valid;
    logic              lk_ready;
    logic [ADDR_W-1:0] lk_addr;
    logic              rsp_valid;
    logic              rsp_hit;
    logic [TAG_W-1:0]  rsp_victim_tag;
    logic              rsp_victim_valid;
    logic              wc_valid;
    logic              wc_ready;
    logic              wc_op;
    logic [ADDR_W-1:0] wc_addr;
    logic [IDX_W-1:0]  tag_rd_addr;
    logic [TAG_W:0]    tag_rd_data;
    logic [IDX_W-1:0]  tag_wr_addr;
    logic [TAG_W:0]    tag_wr_data;
    logic              tag_wr_en;
    logic              init_done;
`ifdef DCACHE_TAG_STATS_EN
    logic [31:0]       stat_hits;
    logic [31:0]       stat_misses;
`endif

    always #5 clk = ~clk;

    dcache_tag_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .lk_valid         (lk_valid),
        .lk_ready         (lk_ready),
        .lk_addr          (lk_addr),
        .rsp_valid        (rsp_valid),
        .rsp_hit          (rsp_hit),
        .rsp_victim_tag   (rsp_victim_tag),
        .rsp_victim_valid (rsp_victim_valid),
        .wc_valid         (wc_valid),
        .wc_ready         (wc_ready),
        .wc_op            (wc_op),
        .wc_addr          (wc_addr),
        .tag_rd_addr      (tag_rd_addr),
        .tag_rd_data      (tag_rd_data),
        .tag_wr_addr      (tag_wr_addr),
        .tag_wr_data      (tag_wr_data),
        .tag_wr_en        (tag_wr_en),
        .init_done        (init_done)
`ifdef DCACHE_TAG_STATS_EN
        ,
        .stat_hits        (stat_hits),
        .stat_misses      (stat_misses)
`endif
    );

    // Tag RAM model; a read colliding with a write returns corrupted data.
    logic [TAG_W:0] mem [0:DEPTH-1];
    logic [TAG_W:0] ram_q = '0;
    always @(posedge clk) begin
        if (tag_wr_en) mem[tag_wr_addr] <= tag_wr_data;
        if (tag_wr_en && (tag_wr_addr == tag_rd_addr)) ram_q <= ~tag_wr_data;
        else ram_q <= mem[tag_rd_addr];
    end
    assign tag_rd_data = ram_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             hit;
        logic [TAG_W-1:0] vtag;
        logic             vvalid;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Called right after a negedge: accept happens at the next posedge, response two edges later.
    task automatic lk_push(input logic [ADDR_W-1:0] a, input logic h, input logic [TAG_W-1:0] vt,
                           input logic vv);
        exp_t e;
        lk_valid = 1'b1;
        lk_addr  = a;
        e.hit    = h;
        e.vtag   = vt;
        e.vvalid = vv;
        e.due    = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        lk_valid = 1'b0;
        wc_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL rsp_unexpected: got response at cycle %0d, required none", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({rsp_hit, rsp_victim_tag, rsp_victim_valid} !== {e.hit, e.vtag, e.vvalid}
                        || cyc != e.due) begin
                        bad++;
                        $display("FAIL rsp_check: got hit=%0b vtag=%h vvalid=%0b cyc=%0d, required hit=%0b vtag=%h vvalid=%0b cyc=%0d",
                                 rsp_hit, rsp_victim_tag, rsp_victim_valid, cyc,
                                 e.hit, e.vtag, e.vvalid, e.due);
                    end
                end
            end else if (sb.size() != 0 && sb[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: no response by cycle %0d, required at %0d", cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({rsp_valid, rsp_hit, rsp_victim_tag, rsp_victim_valid, init_done, tag_wr_en, lk_ready, wc_ready}
            !== '0) begin
            bad++;
            $display("FAIL reset_state: got rv=%0b hit=%0b vt=%h vv=%0b done=%0b wen=%0b lkr=%0b wcr=%0b, required all 0",
                     rsp_valid, rsp_hit, rsp_victim_tag, rsp_victim_valid, init_done, tag_wr_en,
                     lk_ready, wc_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            total++;
            if ({tag_wr_en, tag_wr_addr, tag_wr_data, lk_ready, wc_ready, init_done}
                !== {1'b1, IDX_W'(k), {(TAG_W+1){1'b0}}, 3'b000}) begin
                bad++;
                $display("FAIL init_sweep: cycle %0d got wen=%0b addr=%0d data=%h lkr=%0b wcr=%0b done=%0b, required 1 %0d 0 0 0 0",
                         k, tag_wr_en, tag_wr_addr, tag_wr_data, lk_ready, wc_ready, init_done, k);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if ({init_done, lk_ready, wc_ready, tag_wr_en} !== 4'b1110) begin
            bad++;
            $display("FAIL init_done: got done=%0b lkr=%0b wcr=%0b wen=%0b, required 1 1 1 0",
                     init_done, lk_ready, wc_ready, tag_wr_en);
        end
    endtask

    task automatic test_miss();
        @(negedge clk);
        lk_push(32'h0000_1008, 1'b0, '0, 1'b0);
        #1;
        total++;
        if (tag_rd_addr !== 9'd1) begin
            bad++;
            $display("FAIL rd_addr: got %0d, required 1", tag_rd_addr);
        end
        @(negedge clk);
        idle(4);
    endtask

    task automatic test_fill_hit();
        wc_valid = 1'b1;
        wc_op    = 1'b0;
        wc_addr  = 32'h0000_1008;
        #1;
        total++;
        if ({tag_wr_en, tag_wr_addr, tag_wr_data} !== {1'b1, 9'd1, 21'h100001}) begin
            bad++;
            $display("FAIL fill_write: got wen=%0b addr=%0d data=%h, required 1 1 100001",
                     tag_wr_en, tag_wr_addr, tag_wr_data);
        end
        @(negedge clk);
        wc_valid = 1'b0;
        lk_push(32'h0000_1008, 1'b1, 20'h00001, 1'b1);
        @(negedge clk);
        lk_push(32'h0000_2008, 1'b0, 20'h00001, 1'b1);
        @(negedge clk);
        idle(4);
    endtask

    task automatic test_forward();
        // Fill and lookup together: served by the registered-write path.
        wc_valid = 1'b1;
        wc_op    = 1'b0;
        wc_addr  = 32'hABCD_E010;
        lk_push(32'hABCD_E010, 1'b1, 20'hABCDE, 1'b1);
        @(negedge clk);
        wc_valid = 1'b0;
        lk_push(32'hABCD_E010, 1'b0, '0, 1'b0);
        @(negedge clk);
        // Invalidate during the previous lookup's compare cycle.
        lk_valid = 1'b0;
        wc_valid = 1'b1;
        wc_op    = 1'b1;
        wc_addr  = 32'hABCD_E010;
        #1;
        total++;
        if ({tag_wr_en, tag_wr_addr, tag_wr_data} !== {1'b1, 9'd2, 21'h0}) begin
            bad++;
            $display("FAIL inval_write: got wen=%0b addr=%0d data=%h, required 1 2 0",
                     tag_wr_en, tag_wr_addr, tag_wr_data);
        end
        @(negedge clk);
        wc_valid = 1'b0;
        lk_push(32'hABCD_E010, 1'b0, '0, 1'b0);
        @(negedge clk);
        idle(4);
    endtask

    task automatic test_back_to_back();
        int cnt;
        int rises;
        logic prev;
        logic [TAG_W:0] exp_e [0:7];
        for (int i = 0; i < 8; i++) exp_e[i] = '0;
        exp_e[1] = {1'b1, 20'h00001};
        exp_e[3] = {1'b1, 20'h00000};
        wc_valid = 1'b1;
        wc_op    = 1'b0;
        wc_addr  = 32'h0000_0018;
        @(negedge clk);
        wc_valid = 1'b0;
        cnt   = 0;
        rises = 0;
        prev  = 1'b0;
        for (int j = 0; j < 12; j++) begin
            if (j != 0) @(negedge clk);
            if (j < 8) lk_push(ADDR_W'(j) << OFS_W, exp_e[j][TAG_W] && (exp_e[j][TAG_W-1:0] == '0),
                               exp_e[j][TAG_W-1:0], exp_e[j][TAG_W]);
            else lk_valid = 1'b0;
            #1;
            if (rsp_valid) cnt++;
            if (rsp_valid && !prev) rises++;
            prev = rsp_valid;
        end
        total++;
        if (cnt != 8 || rises != 1) begin
            bad++;
            $display("FAIL back_to_back: got %0d responses in %0d bursts, required 8 in 1", cnt, rises);
        end
        @(negedge clk);
        idle(4);
    endtask

    task automatic test_reset_mid();
        int found;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        found = 0;
        for (int i = 0; i < 300 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (tag_wr_en && tag_wr_addr == 9'd200) found = 1;
        end
        total++;
        if (found != 1) begin
            bad++;
            $display("FAIL sweep_200: got found=%0d, required 1", found);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({tag_wr_en, init_done, lk_ready} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset: got wen=%0b done=%0b lkr=%0b, required 0 0 0",
                     tag_wr_en, init_done, lk_ready);
        end
        rst = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            total++;
            if ({tag_wr_en, tag_wr_addr, init_done} !== {1'b1, IDX_W'(k), 1'b0}) begin
                bad++;
                $display("FAIL resweep: cycle %0d got wen=%0b addr=%0d done=%0b, required 1 %0d 0",
                         k, tag_wr_en, tag_wr_addr, init_done, k);
            end
        end
        @(negedge clk);
        #1;
        total++;
        if (init_done !== 1'b1) begin
            bad++;
            $display("FAIL resweep_done: got %0b, required 1", init_done);
        end
        // Earlier fill at idx 1 must be gone after the sweep.
        lk_push(32'h0000_1008, 1'b0, '0, 1'b0);
        @(negedge clk);
        idle(5);
    endtask

    initial begin
        rst      = 1'b1;
        lk_valid = 1'b0;
        lk_addr  = '0;
        wc_valid = 1'b0;
        wc_op    = 1'b0;
        wc_addr  = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_miss();
        test_fill_hit();
        test_forward();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
